// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared widths, bubble encoding and fetch FSM states
package if_fetch_stage_pkg;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;
    localparam logic [WORD_W-1:0] NOP_DEFAULT = 16'h0800;
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } fsm_t;
endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// if_fetch_stage_pc_reg: program counter with reset, redirect and increment muxing
module if_fetch_stage_pc_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc_q,
    output logic [ADDR_W-1:0] pc_inc
);
    assign pc_inc = pc_q + ADDR_W'(1);
    // Redirect outranks the post-fetch increment; wraps modulo 2^16
    always_ff @(posedge CLK)
        if (RST) pc_q <= RESET_PC;
        else if (redirect) pc_q <= redirect_pc;
        else if (inc) pc_q <= pc_inc;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner, imem fetch control and single output slot feeding IF/ID
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_DEFAULT,
    parameter int                MAX_WAIT  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              imem_busy,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [WORD_W-1:0] instr_out,
    output logic              fetch_err
);
    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);
    fsm_t state_q, state_d;
    logic [WC_W-1:0] wait_q, wait_d;
    logic err_d, fetch_done, miss, slot_v;
    logic [WORD_W-1:0] slot_instr;
    logic [ADDR_W-1:0] slot_pc1, pc_q, pc_inc;

    if_fetch_stage_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .CLK(CLK), .RST(RST), .redirect(redirect), .redirect_pc(redirect_pc),
        .inc(fetch_done), .pc_q(pc_q), .pc_inc(pc_inc)
    );

    assign imem_addr = pc_q;
    assign pc_out    = slot_pc1;
    assign instr_out = slot_v ? slot_instr : NOP_INSTR;

    // Request gating, next FSM state and wait-cycle bookkeeping
    always_comb begin
        imem_req   = !RST && state_q != ST_BOOT && !imem_busy && (!slot_v || !stall);
        fetch_done = imem_req && imem_ack;
        miss       = imem_req && !imem_ack && !redirect;
        state_d    = (state_q == ST_BOOT || redirect || fetch_done) ? ST_RUN : miss ? ST_WAIT : state_q;
        wait_d     = (redirect || fetch_done) ? '0 : (miss && wait_q != WAIT_MAX) ? wait_q + WC_W'(1) : wait_q;
        err_d      = fetch_err || wait_d == WAIT_MAX;
    end

    // FSM state, wait counter and sticky error register
    always_ff @(posedge CLK)
        if (RST) begin
            state_q   <= ST_BOOT;
            wait_q    <= '0;
            fetch_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            fetch_err <= err_d;
        end

    // Output slot: redirect flushes, fetch fills, consume empties, stall holds
    always_ff @(posedge CLK)
        if (RST) begin
            slot_v     <= 1'b0;
            slot_instr <= NOP_INSTR;
            slot_pc1   <= RESET_PC;
        end else if (redirect) begin
            slot_v <= 1'b0;
        end else if (fetch_done) begin
            slot_v     <= 1'b1;
            slot_instr <= imem_rdata;
            slot_pc1   <= pc_inc;
        end else if (!stall) begin
            slot_v <= 1'b0;
        end
endmodule
